// File: rtl/adc_pkg.sv
// adc_pkg: shared FSM encoding and accumulator width for adc_pulse_sampler
package adc_pkg;
    typedef enum logic [2:0] {PWRUP, ARM, DELAY, CONVERT, SHIFT, ACCUM, DONE} state_t;
    localparam int ADC_BITS_DEF = 12;
    localparam int AVG_LOG2_DEF = 3;
    localparam int ACC_W = ADC_BITS_DEF + AVG_LOG2_DEF;
    function automatic int acc_width(input int adc_bits, input int avg_log2);
        return adc_bits + avg_log2;
    endfunction
endpackage

// File: rtl/adc_serial_rx.sv
// adc_serial_rx: shared SCK generator and per-channel SDO shift registers, SCK idles low
module adc_serial_rx #(
    parameter int NCH      = 2,
    parameter int ADC_BITS = 12,
    parameter int SCK_HALF = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          i_start,
    input  logic [NCH-1:0]                i_sdo,
    output logic                          o_sck,
    output logic                          o_done,
    output logic [NCH-1:0][ADC_BITS-1:0]  o_data
);
    localparam int NB = ADC_BITS + 2;
    localparam int BW = $clog2(NB);
    localparam int HW = $clog2(SCK_HALF + 1);
    logic                         r_active;
    logic                         r_sck;
    logic                         r_done;
    logic [BW-1:0]                r_bits;
    logic [HW-1:0]                r_half;
    logic [NCH-1:0][ADC_BITS-1:0] r_sh;
    logic                         w_half_end;
    logic                         w_shift;
    assign w_half_end = r_half == HW'(SCK_HALF - 1);
    assign w_shift    = r_active ? (w_half_end && !r_sck && r_bits != BW'(NB - 1)) : i_start;
    assign o_sck      = r_sck;
    assign o_done     = r_done;
    assign o_data     = r_sh;
    // SCK half-period timing; every rising SCK edge coincides with an SDO sample
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_active <= 1'b0;
            r_sck    <= 1'b0;
            r_done   <= 1'b0;
            r_bits   <= '0;
            r_half   <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_active) begin
                if (i_start) begin
                    r_active <= 1'b1;
                    r_sck    <= 1'b1;
                    r_half   <= '0;
                    r_bits   <= '0;
                end
            end else if (!w_half_end) begin
                r_half <= r_half + 1'b1;
            end else begin
                r_half <= '0;
                if (r_sck) begin
                    r_sck <= 1'b0;
                end else if (r_bits == BW'(NB - 1)) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end else begin
                    r_sck  <= 1'b1;
                    r_bits <= r_bits + 1'b1;
                end
            end
        end
    end
    // MSB-first shift; the two leading zeros fall off the top after NB shifts
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_sh <= '0;
        else if (w_shift) for (int c = 0; c < NCH; c++) r_sh[c] <= {r_sh[c][ADC_BITS-2:0], i_sdo[c]};
    end
endmodule

// File: rtl/adc_pulse_sampler.sv
// adc_pulse_sampler: laser-triggered multi-channel ADC burst sampler with average and peak (optional ADC_TRIP_EN adds trip outputs)
module adc_pulse_sampler
    import adc_pkg::*;
#(
    parameter int NCH           = 2,
    parameter int ADC_BITS      = ADC_BITS_DEF,
    parameter int OUT_W         = 16,
    parameter int AVG_LOG2      = AVG_LOG2_DEF,
    parameter int CONVERT_DELAY = 3000,
    parameter int CONV_CYCLES   = 21,
    parameter int SCK_HALF      = 1,
    parameter int PWRUP_CYCLES  = 65520
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_laser_pulse,
    input  logic                 i_clear_peak,
    input  logic [NCH-1:0]       i_adc_sdo,
`ifdef ADC_TRIP_EN
    input  logic [OUT_W-1:0]     i_trip_level,
    output logic [NCH-1:0]       o_trip,
`endif
    output logic                 o_adc_sck,
    output logic                 o_adc_convert,
    output logic                 o_start_timer,
    output logic                 o_laser_pulse_delay,
    output logic                 o_busy,
    output logic                 o_avg_valid,
    output logic [NCH*OUT_W-1:0] o_avg_data,
    output logic [NCH*OUT_W-1:0] o_peak_data
);
    localparam int ACC_WL = acc_width(ADC_BITS, AVG_LOG2);
    state_t                       r_state;
    state_t                       w_next;
    logic [1:0]                   r_sync;
    logic                         r_sync_d;
    logic                         w_rise;
    logic [31:0]                  r_cnt;
    logic [AVG_LOG2-1:0]          r_smp;
    logic                         r_start_timer;
    logic                         r_avg_valid;
    logic                         w_rx_start;
    logic                         w_rx_done;
    logic                         w_first_done;
    logic [NCH-1:0][ADC_BITS-1:0] w_rx_data;
    logic [NCH-1:0][ACC_WL-1:0]   r_acc;
    logic [NCH-1:0][OUT_W-1:0]    r_avg;
    logic [NCH-1:0][OUT_W-1:0]    r_peak;
    adc_serial_rx #(.NCH(NCH), .ADC_BITS(ADC_BITS), .SCK_HALF(SCK_HALF)) u_rx (
        .clk     (clk),
        .rstn    (rstn),
        .i_start (w_rx_start),
        .i_sdo   (i_adc_sdo),
        .o_sck   (o_adc_sck),
        .o_done  (w_rx_done),
        .o_data  (w_rx_data)
    );
    assign w_rise              = r_sync[1] && !r_sync_d;
    assign w_first_done        = r_state == DONE && r_cnt == '0;
    assign o_laser_pulse_delay = r_sync[1];
    assign o_start_timer       = r_start_timer;
    assign o_adc_convert       = r_state == CONVERT;
    assign o_busy              = !(r_state == PWRUP || r_state == ARM);
    assign o_avg_valid         = r_avg_valid;
    assign o_avg_data          = r_avg;
    assign o_peak_data         = r_peak;
    // Two-flop synchroniser for the asynchronous laser gate plus an edge-detect tap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) {r_sync_d, r_sync} <= '0;
        else {r_sync_d, r_sync} <= {r_sync[1], r_sync[0], i_laser_pulse};
    end
    // State register, per-state cycle counter (saturating so a long DONE wait never re-fires the strobe)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= PWRUP;
            r_cnt         <= '0;
            r_start_timer <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_cnt         <= (w_next != r_state) ? '0 : (r_cnt == '1) ? r_cnt : r_cnt + 32'd1;
            r_start_timer <= w_next == DELAY;
        end
    end
    // Next-state logic; laser edges are only looked at in ARM, so a burst cannot be retriggered
    always_comb begin
        w_next     = r_state;
        w_rx_start = 1'b0;
        case (r_state)
            PWRUP:   w_next = (r_cnt == PWRUP_CYCLES - 1) ? ARM : PWRUP;
            ARM:     w_next = w_rise ? DELAY : ARM;
            DELAY:   w_next = (r_cnt == CONVERT_DELAY - 1) ? CONVERT : DELAY;
            CONVERT: begin
                w_rx_start = r_cnt == CONV_CYCLES - 1;
                w_next     = w_rx_start ? SHIFT : CONVERT;
            end
            SHIFT:   w_next = w_rx_done ? ACCUM : SHIFT;
            ACCUM:   w_next = (r_smp == '1) ? DONE : CONVERT;
            DONE:    w_next = (r_cnt != '0 && !r_sync[1]) ? ARM : DONE;
            default: w_next = PWRUP;
        endcase
    end
    // Burst accumulation; cleared together with the peak update on the strobe cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc <= '0;
            r_smp <= '0;
        end else if (r_avg_valid) begin
            r_acc <= '0;
        end else if (r_state == ACCUM) begin
            r_smp <= r_smp + 1'b1;
            for (int c = 0; c < NCH; c++) r_acc[c] <= r_acc[c] + ACC_WL'(w_rx_data[c]);
        end
    end
    // Average is latched on entry to DONE so it is stable while avg_valid strobes the next cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= w_first_done;
            if (w_first_done) for (int c = 0; c < NCH; c++) r_avg[c] <= OUT_W'(r_acc[c][ACC_WL-1:AVG_LOG2]);
        end
    end
    // Running peak; a new average overrides a simultaneous clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_peak <= '0;
        else for (int c = 0; c < NCH; c++)
            r_peak[c] <= r_avg_valid ? ((i_clear_peak || r_avg[c] > r_peak[c]) ? r_avg[c] : r_peak[c])
                       : i_clear_peak ? '0 : r_peak[c];
    end
`ifdef ADC_TRIP_EN
    logic [NCH-1:0] r_trip;
    assign o_trip = r_trip;
    // Sticky over-level flags; setting beats a simultaneous clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_trip <= '0;
        else for (int c = 0; c < NCH; c++)
            r_trip[c] <= (r_avg_valid && r_avg[c] > i_trip_level) ? 1'b1 : i_clear_peak ? 1'b0 : r_trip[c];
    end
`endif
endmodule
